neuron_mac_sequencer: RTL and testbench

//  Front-end/back-end stage around dadda_multiplier in the neuron datapath.
//  - Accepts (weight, activation) pairs and issues each pair to the multiplier as a signed x signed request.
//  - Adds each product into a 32-bit membrane potential.
//  - At the end of a timestep: applies leak, compares against threshold, emits a spike and resets the potential.

---
 rtl/neuron_mac_sequencer.sv | 151 +++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_sequencer.sv
// Purpose: issues (weight, activation) pairs to a signed multiplier, accumulates a membrane potential, leaks/fires per timestep (NEURON_SAT_ACCUM_EN selects saturating arithmetic).
// Latency: IDLE + ISSUE + multiplier latency + ACCUM per pair; the end of a timestep adds LEAK and, on a spike, EMIT.
// Backpressure: in_ready only in IDLE; ISSUE waits on mul_ready; EMIT holds the spike until spike_ready.
module neuron_mac_sequencer #(
    parameter logic signed [31:0] THRESHOLD   = 32'sd1000,
    parameter logic signed [31:0] LEAK        = 32'sd1,
    parameter logic signed [31:0] V_RESET     = 32'sd0,
    parameter int                 MUL_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_weight,
    input  logic [31:0] in_act,
    input  logic        in_last,
    output logic        mul_start,
    output logic [1:0]  mul_type,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ready,
    input  logic        mul_done,
    input  logic [31:0] mul_answer,
    output logic        spike_valid,
    input  logic        spike_ready,
    output logic [31:0] spike_potential,
    output logic [31:0] potential,
    output logic        err_timeout
);
    localparam int CW = $clog2(MUL_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACCUM, S_LEAK, S_EMIT} state_t;

    state_t             state, state_nxt;
    logic [31:0]        weight_q, act_q, product_q;
    logic               last_q;
    logic [CW-1:0]      cnt_q;
    logic signed [31:0] potential_q, spike_pot_q, acc_sum, leaked;
    logic               err_q, timeout_hit, fire;

    function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
`ifdef NEURON_SAT_ACCUM_EN
        if (a[31] == b[31] && s[31] != a[31])
            s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return s;
    endfunction

    function automatic logic [31:0] sub32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a - b;
`ifdef NEURON_SAT_ACCUM_EN
        if (a[31] != b[31] && s[31] != a[31])
            s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return s;
    endfunction

    assign acc_sum     = add32(potential_q, product_q);
    assign leaked      = sub32(potential_q, LEAK);
    assign fire        = (leaked >= THRESHOLD);
    assign timeout_hit = (cnt_q == CW'(MUL_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_ISSUE;
            S_ISSUE: if (mul_ready) state_nxt = S_WAIT;
            S_WAIT:  if (mul_done || timeout_hit) state_nxt = S_ACCUM;
            S_ACCUM: state_nxt = last_q ? S_LEAK : S_IDLE;
            S_LEAK:  state_nxt = fire ? S_EMIT : S_IDLE;
            S_EMIT:  if (spike_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Gated by rst so every control output reads 0 while reset is held.
    always_comb begin
        in_ready    = 1'b0;
        mul_start   = 1'b0;
        mul_type    = 2'b00;
        spike_valid = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE:  in_ready = 1'b1;
                S_ISSUE: begin
                    mul_type  = 2'b01;
                    mul_start = mul_ready;
                end
                S_EMIT:  spike_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            weight_q    <= '0;
            act_q       <= '0;
            last_q      <= 1'b0;
            product_q   <= '0;
            cnt_q       <= '0;
            potential_q <= '0;
            spike_pot_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    weight_q <= in_weight;
                    act_q    <= in_act;
                    last_q   <= in_last;
                end
                S_ISSUE: cnt_q <= '0;
                // A product arriving on the final wait cycle still counts.
                S_WAIT: begin
                    if (mul_done) begin
                        product_q <= mul_answer;
                    end else if (timeout_hit) begin
                        product_q <= '0;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_ACCUM: potential_q <= acc_sum;
                S_LEAK: begin
                    if (fire) begin
                        spike_pot_q <= leaked;
                        potential_q <= V_RESET;
                    end else begin
                        potential_q <= leaked;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_a           = weight_q;
    assign mul_b           = act_q;
    assign spike_potential = spike_pot_q;
    assign potential       = potential_q;
    assign err_timeout     = err_q;
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench for neuron_mac_sequencer: directed vector table, multi-cycle corner sequences and
// randomized pairs scored against an arithmetic model of the neuron.
module tb_neuron_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_weight = '0;
    logic [31:0] in_act = '0;
    logic        in_last = 1'b0;
    logic        mul_start;
    logic [1:0]  mul_type;
    logic [31:0] mul_a, mul_b;
    logic        mul_ready = 1'b1;
    logic        mul_done = 1'b0;
    logic [31:0] mul_answer = '0;
    logic        spike_valid;
    logic        spike_ready = 1'b0;
    logic [31:0] spike_potential, potential;
    logic        err_timeout;

    always #5 clk = ~clk;

    neuron_mac_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_weight(in_weight), .in_act(in_act), .in_last(in_last),
        .mul_start(mul_start), .mul_type(mul_type), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_done(mul_done), .mul_answer(mul_answer),
        .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_potential(spike_potential),
        .potential(potential), .err_timeout(err_timeout)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_starts = 0;
    logic [31:0] st_a = '0, st_b = '0;
    logic [1:0]  st_type = '0;
    int          lat = 0;
    bit          mute = 1'b0;
    logic signed [31:0] ref_pot = '0;

    // Multiplier model: answers a*b (low 32 bits) lat+1 cycles after the start cycle.
    initial begin : mul_model
        bit          busy;
        bit          started;
        int          cnt;
        logic [31:0] res, a, b;
        busy = 1'b0; cnt = 0; res = '0;
        forever begin
            @(posedge clk);
            started = mul_start;
            a = mul_a;
            b = mul_b;
            if (started) begin
                n_starts++;
                st_a = a; st_b = b; st_type = mul_type;
            end
            #1;
            mul_done = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    busy = 1'b0;
                    if (!mute) begin
                        mul_done = 1'b1;
                        mul_answer = res;
                    end
                end else begin
                    cnt--;
                end
            end
            if (started) begin
                busy = 1'b1;
                cnt = lat;
                res = a * b;
            end
            mul_ready = !busy;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        spike_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ref_pot = '0;
    endtask

    task automatic send_pair(input logic [31:0] w, input logic [31:0] a, input logic l);
        int k;
        in_weight = w; in_act = a; in_last = l; in_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            if (in_ready) break;
        end
        #1 in_valid = 1'b0;
        if (k == 200) fail("in_ready handshake");
    endtask

    task automatic wait_settle();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready || spike_valid) break;
        end
        if (k == 300) fail("settle");
    endtask

    task automatic drain_spike();
        int k;
        @(posedge clk);
        #1 spike_ready = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        spike_ready = 1'b0;
        if (k == 50) fail("spike drain");
    endtask

    task automatic do_pair(input logic [31:0] w, input logic [31:0] a, input logic l, input int hold,
                           input logic [31:0] ep, input logic es, input logic [31:0] esp, input string tag);
        int s0;
        s0 = n_starts;
        send_pair(w, a, l);
        wait_settle();
        check({tag, " starts"}, 32'(n_starts - s0), 32'd1);
        check({tag, " mul_a"}, st_a, w);
        check({tag, " mul_b"}, st_b, a);
        check({tag, " mul_type"}, 32'(st_type), 32'd1);
        check({tag, " spike_valid"}, 32'(spike_valid), 32'(es));
        if (es) begin
            check({tag, " spike_potential"}, spike_potential, esp);
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                check({tag, " spike held"}, 32'(spike_valid), 32'd1);
                check({tag, " in_ready in EMIT"}, 32'(in_ready), 32'd0);
            end
        end
        if (spike_valid) drain_spike();
        if (es) check({tag, " spike cleared"}, 32'(spike_valid), 32'd0);
        check({tag, " potential"}, potential, ep);
    endtask

    function automatic logic [31:0] ref_fix(input longint s);
`ifdef NEURON_SAT_ACCUM_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    // Reference neuron: plain integer arithmetic on the timestep rules.
    task automatic ref_step(input logic [31:0] w, input logic [31:0] a, input logic l, input int hold, input string tag);
        longint      p;
        logic [31:0] prod, pot, lk, esp;
        logic        es;
        p    = longint'($signed(w)) * longint'($signed(a));
        prod = p[31:0];
        pot  = ref_fix(longint'(ref_pot) + longint'($signed(prod)));
        es   = 1'b0;
        esp  = '0;
        if (l) begin
            lk = ref_fix(longint'($signed(pot)) - 64'sd1);
            if ($signed(lk) >= 32'sd1000) begin
                es = 1'b1; esp = lk; pot = '0;
            end else begin
                pot = lk;
            end
        end
        ref_pot = pot;
        do_pair(w, a, l, hold, pot, es, esp, tag);
    endtask

    typedef struct {
        bit          rst_first;
        logic [31:0] w;
        logic [31:0] a;
        bit          l;
        int          hold;
        logic [31:0] ep;
        bit          es;
        logic [31:0] esp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int s0;
        int k;
        logic [31:0] w, a;
        tbl[0] = '{1'b1, 32'd3,    -32'sd5, 1'b0, 0, -32'sd15, 1'b0, 32'd0};
        tbl[1] = '{1'b1, 32'd100,  32'd5,   1'b0, 0, 32'd500,  1'b0, 32'd0};
        tbl[2] = '{1'b0, 32'd100,  32'd6,   1'b1, 5, 32'd0,    1'b1, 32'd1099};
        tbl[3] = '{1'b0, 32'd10,   32'd10,  1'b1, 0, 32'd99,   1'b0, 32'd0};
        tbl[4] = '{1'b0, -32'sd50, 32'd2,   1'b1, 0, -32'sd2,  1'b0, 32'd0};
        tbl[5] = '{1'b0, 32'd1000, 32'd1,   1'b1, 0, 32'd997,  1'b0, 32'd0};
        tbl[6] = '{1'b0, 32'd4,    32'd1,   1'b1, 0, 32'd0,    1'b1, 32'd1000};
        tbl[7] = '{1'b0, 32'd1000, 32'd1,   1'b1, 2, 32'd999,  1'b0, 32'd0};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst mul_start", 32'(mul_start), 32'd0);
        check("rst mul_type", 32'(mul_type), 32'd0);
        check("rst mul_a", mul_a, 32'd0);
        check("rst mul_b", mul_b, 32'd0);
        check("rst spike_valid", 32'(spike_valid), 32'd0);
        check("rst spike_potential", spike_potential, 32'd0);
        check("rst potential", potential, 32'd0);
        check("rst err_timeout", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("in_ready after release", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst_first) do_reset();
            lat = i % 3;
            do_pair(tbl[i].w, tbl[i].a, tbl[i].l, tbl[i].hold, tbl[i].ep, tbl[i].es, tbl[i].esp,
                    $sformatf("vec%0d", i));
        end

        // Product landing on the last allowed wait cycle beats the timeout
        do_reset();
        lat = 0;
        do_pair(32'd2, 32'd3, 1'b0, 0, 32'd6, 1'b0, 32'd0, "edge pre");
        lat = 30;
        send_pair(32'd9, 32'd9, 1'b0);
        wait_settle();
        check("edge err_timeout", 32'(err_timeout), 32'd0);
        check("edge potential", potential, 32'd87);

        // Multiplier never answers
        lat = 0;
        mute = 1'b1;
        s0 = n_starts;
        send_pair(32'd7, 32'd7, 1'b0);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (n_starts != s0) break;
        end
        if (k == 50) fail("timeout start");
        repeat (31) @(negedge clk);
        check("err_timeout before limit", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check("err_timeout at limit", 32'(err_timeout), 32'd1);
        wait_settle();
        check("timeout potential", potential, 32'd87);
        check("timeout in_ready", 32'(in_ready), 32'd1);
        mute = 1'b0;
        do_pair(32'd1, 32'd1, 1'b0, 0, 32'd88, 1'b0, 32'd0, "after timeout");
        check("err_timeout sticky", 32'(err_timeout), 32'd1);
        do_reset();
        check("err_timeout cleared", 32'(err_timeout), 32'd0);

        // Overflow behaviour on accumulate and leak
        ref_step(32'h7FFF_FFF0, 32'd1, 1'b0, 0, "sat1");
        ref_step(32'h0000_0100, 32'd1, 1'b0, 0, "sat2");
`ifdef NEURON_SAT_ACCUM_EN
        check("accum overflow", potential, 32'h7FFF_FFFF);
`else
        check("accum overflow", potential, 32'h8000_00F0);
`endif
        do_reset();
        ref_step(32'h8000_0000, 32'd1, 1'b1, 1, "leak overflow");

        // Reset while waiting; stale product arrives three cycles later
        do_reset();
        lat = 0;
        do_pair(32'd2, 32'd3, 1'b0, 0, 32'd6, 1'b0, 32'd0, "midrst pre");
        lat = 3;
        s0 = n_starts;
        send_pair(32'd5, 32'd5, 1'b0);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (n_starts != s0) break;
        end
        if (k == 50) fail("midrst start");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst potential", potential, 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst spike_valid", 32'(spike_valid), 32'd0);
        lat = 0;
        ref_pot = '0;
        ref_step(32'd2, 32'd3, 1'b0, 0, "midrst post");

        // Randomized pairs against the reference model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            lat = $urandom_range(0, 4);
            w = 32'($urandom_range(0, 200)) - 32'd100;
            a = 32'($urandom_range(0, 200)) - 32'd100;
            if ($urandom_range(0, 9) == 0) w = $urandom;
            ref_step(w, a, ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
